// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// axi_pkg : shared AXI read-path types and default widths
// Rev 1.0
// ============================================================================
package axi_pkg;

  localparam int c_ADDR_BITS = 32;
  localparam int c_DATA_BITS = 32;
  localparam int c_LEN_BITS  = 8;
  localparam int c_SIZE_BITS = 3;

  localparam logic [3:0] c_AR_CACHE = 4'b0011;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_rd_skid_buf.sv
`default_nettype none
// ============================================================================
// axi_rd_skid_buf : 2-entry valid/ready skid buffer with registered outputs
// Rev 1.0
// ============================================================================
module axi_rd_skid_buf #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  logic             r_out_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_push;
  logic             w_load;

  assign o_in_ready  = !r_skid_valid;
  assign w_push      = i_in_valid && !r_skid_valid;
  assign w_load      = !r_out_valid || i_out_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

  // The skid entry only fills while the output entry is stalled, so it always
  // holds the older beat and must drain into the output register first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (w_load) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_push;
        if (w_push) r_out_data <= i_in_data;
      end
    end else if (w_push) begin
      r_skid_data  <= i_in_data;
      r_skid_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_master_rd.sv
`default_nettype none
// ============================================================================
// axi_master_rd : single-outstanding AXI read master with LAST/RESP checking
// Rev 1.0
// ============================================================================
module axi_master_rd
  import axi_pkg::*;
#(
  parameter int ADDR_BITS = c_ADDR_BITS,
  parameter int DATA_BITS = c_DATA_BITS,
  parameter int LEN_BITS  = c_LEN_BITS,
  parameter int SIZE_BITS = c_SIZE_BITS
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic [SIZE_BITS-1:0] cmd_size,
  input  logic [1:0]           cmd_burst,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_BITS-1:0] ar_addr,
  output logic [LEN_BITS-1:0]  ar_len,
  output logic [SIZE_BITS-1:0] ar_size,
  output logic [1:0]           ar_burst,
  output logic [3:0]           ar_cache,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_BITS-1:0] r_data,
  input  logic                 r_last,
  input  logic [1:0]           r_resp,
  output logic                 usr_valid,
  input  logic                 usr_ready,
  output logic [DATA_BITS-1:0] usr_data,
  output logic                 usr_last,
  output logic [1:0]           usr_resp,
  output logic                 done,
  output logic [2:0]           err
);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic [ADDR_BITS-1:0]  r_ar_addr;
  logic [LEN_BITS-1:0]   r_ar_len;
  logic [SIZE_BITS-1:0]  r_ar_size;
  logic [1:0]            r_ar_burst;
  logic [LEN_BITS-1:0]   r_beat_cnt;
  logic                  r_err_resp;
  logic                  r_err_early;
  logic                  r_err_missing;
  logic                  r_done;
  logic                  w_cmd_hs;
  logic                  w_ar_hs;
  logic                  w_beat_valid;
  logic                  w_accept;
  logic                  w_cnt_zero;
  logic [DATA_BITS+2:0]  w_usr_pkt;

  assign w_cmd_hs     = cmd_valid && cmd_ready;
  assign w_ar_hs      = ar_valid && ar_ready;
  assign w_beat_valid = r_valid && (r_state == ST_DATA);
  assign w_accept     = w_beat_valid && r_ready;
  assign w_cnt_zero   = (r_beat_cnt == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    ar_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_accept && r_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ar_addr     <= '0;
      r_ar_len      <= '0;
      r_ar_size     <= '0;
      r_ar_burst    <= '0;
      r_beat_cnt    <= '0;
      r_err_resp    <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_accept && r_last;
      if (w_cmd_hs) begin
        r_ar_addr     <= cmd_addr;
        r_ar_len      <= cmd_len;
        r_ar_size     <= cmd_size;
        r_ar_burst    <= cmd_burst;
        r_err_resp    <= 1'b0;
        r_err_early   <= 1'b0;
        r_err_missing <= 1'b0;
      end
      if (w_ar_hs) r_beat_cnt <= r_ar_len;
      // Flags are sticky for the burst so err is complete when done pulses.
      if (w_accept) begin
        if (!w_cnt_zero)              r_beat_cnt    <= r_beat_cnt - LEN_BITS'(1);
        if (r_resp != RESP_OKAY)      r_err_resp    <= 1'b1;
        if (r_last && !w_cnt_zero)    r_err_early   <= 1'b1;
        if (!r_last && w_cnt_zero)    r_err_missing <= 1'b1;
      end
    end
  end

  axi_rd_skid_buf #(
    .WIDTH (DATA_BITS + 3)
  ) u_skid (
    .clk         (aclk),
    .rst         (areset),
    .i_in_valid  (w_beat_valid),
    .o_in_ready  (r_ready),
    .i_in_data   ({r_data, r_last, r_resp}),
    .o_out_valid (usr_valid),
    .i_out_ready (usr_ready),
    .o_out_data  (w_usr_pkt)
  );

  assign usr_data = w_usr_pkt[DATA_BITS+2:3];
  assign usr_last = w_usr_pkt[2];
  assign usr_resp = w_usr_pkt[1:0];
  assign ar_addr  = r_ar_addr;
  assign ar_len   = r_ar_len;
  assign ar_size  = r_ar_size;
  assign ar_burst = r_ar_burst;
  assign ar_cache = c_AR_CACHE;
  assign done     = r_done;
  assign err      = {r_err_resp, r_err_early, r_err_missing};

endmodule
`default_nettype wire

// File: tb/tb_axi_master_rd.sv
`default_nettype none
// ============================================================================
// tb_axi_master_rd : randomized self-checking bench with a burst-level model
// Rev 1.0
// ============================================================================
module tb_axi_master_rd;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_cache;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [31:0] r_data = '0;
  logic        r_last = 1'b0;
  logic [1:0]  r_resp = '0;
  logic        usr_valid;
  logic        usr_ready = 1'b0;
  logic [31:0] usr_data;
  logic        usr_last;
  logic [1:0]  usr_resp;
  logic        done;
  logic [2:0]  err;

  axi_master_rd dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
    .usr_valid(usr_valid), .usr_ready(usr_ready), .usr_data(usr_data),
    .usr_last(usr_last), .usr_resp(usr_resp), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  r;
  } beat_t;

  beat_t      exp_q[$];
  logic [2:0] exp_err = '0;
  int n_chk = 0, n_err = 0;
  int n_push = 0, n_pop = 0, n_term = 0, n_term_seen = 0;
  int rdy_pct = 100;
  logic hold = 1'b0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Buffer occupancy is simply beats handed in minus beats taken out.
  always @(posedge aclk) begin
    int  occ;
    logic exp_d;
    #2;
    if (mon_en && !areset) begin
      occ = n_push - n_pop;
      chk("r_ready_occ", r_ready, occ < 2);
      chk("usr_valid_occ", usr_valid, occ != 0);
      exp_d = (n_term != n_term_seen);
      n_term_seen = n_term;
      chk("done", done, exp_d);
      if (exp_d) begin
        chk("err_at_done", err, exp_err);
        chk("idle_after_done", cmd_ready, 1);
      end
    end
  end

  always @(negedge aclk) begin
    beat_t b;
    if (hold) usr_ready = 1'b0;
    else      usr_ready = ($urandom_range(0, 99) < rdy_pct);
    if (usr_valid && usr_ready && !areset) begin
      if (exp_q.size() == 0) chk("usr_extra_beat", 1, 0);
      else begin
        b = exp_q.pop_front();
        chk("usr_data", usr_data, b.d);
        chk("usr_last", usr_last, b.l);
        chk("usr_resp", usr_resp, b.r);
      end
      n_pop++;
    end
  end

  task automatic do_cmd(input logic [31:0] addr, input int len, input logic [2:0] size,
                        input logic [1:0] burst, input int ar_dly);
    int g = 0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 8'(len); cmd_size = size; cmd_burst = burst;
    while (!cmd_ready) begin
      @(negedge aclk);
      if (++g > 300) begin chk("cmd_timeout", 0, 1); cmd_valid = 1'b0; return; end
    end
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_burst = 2'($urandom);
    chk("err_clear", err, 0);
    for (int k = 0; k <= ar_dly; k++) begin
      chk("ar_valid", ar_valid, 1);
      chk("ar_addr", ar_addr, addr);
      chk("ar_len", ar_len, len);
      chk("ar_size", ar_size, size);
      chk("ar_burst", ar_burst, burst);
      chk("ar_cache", ar_cache, 4'b0011);
      ar_ready = (k == ar_dly);
      if (k < ar_dly) @(negedge aclk);
    end
    @(negedge aclk);
    ar_ready = 1'b0;
    chk("ar_valid_drop", ar_valid, 0);
  endtask

  // Model: burst ends at the first LAST; early if before beat len, missing if after.
  task automatic send_beats(input int len, input int last_at, input int n_send,
                            input logic [31:0] bad, input int gap_pct);
    logic [31:0] d;
    logic [1:0]  rs;
    logic        lst, acc, e_resp;
    int          g;
    e_resp = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      d   = $urandom;
      rs  = bad[i] ? 2'($urandom_range(1, 3)) : 2'b00;
      lst = (i == last_at);
      acc = 1'b0;
      g   = 0;
      while (!acc) begin
        @(negedge aclk);
        if ($urandom_range(0, 99) < gap_pct) begin
          r_valid = 1'b0; r_data = $urandom; r_last = 1'($urandom);
        end else begin
          r_valid = 1'b1; r_data = d; r_last = lst; r_resp = rs;
          acc = r_ready;
        end
        if (++g > 200) begin chk("r_accept_timeout", 0, 1); r_valid = 1'b0; return; end
      end
      exp_q.push_back({d, lst, rs});
      n_push++;
      if (rs != 2'b00) e_resp = 1'b1;
      if (lst) begin
        exp_err = {e_resp, 1'(i < len), 1'(i > len)};
        n_term++;
      end
    end
    @(negedge aclk);
    r_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0) begin
      @(negedge aclk);
      if (++g > 500) begin chk("drain_timeout", exp_q.size(), 0); exp_q.delete(); break; end
    end
    repeat (2) @(negedge aclk);
    chk("err_hold", err, exp_err);
  endtask

  task automatic check_reset_vals();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_r_ready", r_ready, 1);
    chk("rst_usr_valid", usr_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ar_fields", {ar_addr, ar_len, ar_size, ar_burst}, 0);
  endtask

  initial begin
    int len, last_at, sel;
    repeat (3) @(negedge aclk);
    check_reset_vals();
    areset = 1'b0;
    mon_en = 1'b1;

    do_cmd(32'h100, 3, 3'd2, BURST_INCR, 0);
    send_beats(3, 3, 4, 32'h0, 0);
    drain();

    do_cmd(32'h2000, 3, 3'd2, BURST_INCR, 5);
    send_beats(3, 3, 4, 32'h0, 20);
    drain();

    do_cmd(32'h300, 3, 3'd2, BURST_WRAP, 1);
    send_beats(3, 1, 2, 32'h0, 0);
    drain();
    chk("early_last_err", err, 3'b010);

    do_cmd(32'h400, 1, 3'd2, BURST_INCR, 0);
    send_beats(1, 2, 3, 32'h0, 0);
    drain();
    chk("missing_last_err", err, 3'b001);

    fork
      begin hold = 1'b1; repeat (8) @(negedge aclk); hold = 1'b0; end
      begin do_cmd(32'h500, 7, 3'd2, BURST_INCR, 0); send_beats(7, 7, 8, 32'h0, 0); end
    join
    drain();

    do_cmd(32'h600, 2, 3'd2, BURST_FIXED, 0);
    send_beats(2, 2, 3, 32'h1, 0);
    drain();
    chk("resp_err", err, 3'b100);

    do_cmd(32'h700, 0, 3'd2, BURST_INCR, 2);
    send_beats(0, 0, 1, 32'h0, 0);
    drain();

    // Beats presented while idle must vanish.
    repeat (3) begin
      @(negedge aclk);
      r_valid = 1'b1; r_last = 1'b1; r_data = $urandom;
    end
    @(negedge aclk);
    r_valid = 1'b0;
    repeat (2) @(negedge aclk);

    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      if (sel < 7) last_at = len;
      else if (sel < 8 && len > 0) last_at = $urandom_range(0, len - 1);
      else last_at = len + $urandom_range(1, 2);
      rdy_pct = $urandom_range(20, 100);
      do_cmd($urandom, len, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), $urandom_range(0, 3));
      send_beats(len, last_at, last_at + 1, $urandom & $urandom & $urandom, $urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) drain();
    end
    rdy_pct = 100;
    drain();

    rdy_pct = 0;
    do_cmd(32'h800, 7, 3'd2, BURST_INCR, 0);
    send_beats(7, 7, 2, 32'h0, 0);
    @(negedge aclk);
    mon_en = 1'b0;
    r_valid = 1'b1; r_data = $urandom; r_last = 1'b0;
    areset = 1'b1;
    #1;
    check_reset_vals();
    exp_q.delete();
    n_push = 0; n_pop = 0; n_term = 0; n_term_seen = 0;
    @(negedge aclk);
    areset = 1'b0; r_valid = 1'b0; rdy_pct = 100; mon_en = 1'b1;
    do_cmd(32'h900, 3, 3'd2, BURST_INCR, 0);
    send_beats(3, 3, 4, 32'h2, 10);
    drain();
    chk("post_reset_err", err, 3'b100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
